// File: rtl/dpram_fifo.sv
// First-word-fall-through FIFO wrapped around a single dual-port block RAM.
// A two-entry output stage absorbs the RAM's one-cycle read latency.

module dpram #(
  parameter int VECTOR_LENGTH = 512,
  parameter int WORD_WIDTH    = 8,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  rclk_i,
  input  logic                  rclke_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  input  logic                  wclk_i,
  input  logic                  wclke_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_WIDTH-1:0] mask_i,
  input  logic [WORD_WIDTH-1:0] wdata_i
);

  logic [WORD_WIDTH-1:0] mem_r [VECTOR_LENGTH];
  logic [WORD_WIDTH-1:0] rdata_r;

  // Masked write port: a set mask bit preserves the stored bit.
  always_ff @(posedge wclk_i) begin
    if (wclke_i && we_i) begin
      mem_r[waddr_i] <= (mem_r[waddr_i] & mask_i) | (wdata_i & ~mask_i);
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge rclk_i) begin
    if (rclke_i && re_i) begin
      rdata_r <= mem_r[raddr_i];
    end
  end

  assign rdata_o = rdata_r;

endmodule

module dpram_fifo #(
  parameter int VECTOR_LENGTH = 512,
  parameter int WORD_WIDTH    = 8,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH),
  parameter int LEVEL_WIDTH   = $clog2(VECTOR_LENGTH + 3)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [WORD_WIDTH-1:0]  in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [WORD_WIDTH-1:0]  out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LEVEL_WIDTH-1:0] level_o
);

  logic [ADDR_WIDTH-1:0]  wptr_r;
  logic [ADDR_WIDTH-1:0]  rptr_r;
  logic [LEVEL_WIDTH-1:0] ram_count_r;
  logic                   pending_r;
  logic                   head_valid_r;
  logic                   skid_valid_r;
  logic [WORD_WIDTH-1:0]  head_r;
  logic [WORD_WIDTH-1:0]  skid_r;

  logic                   flush_s;
  logic                   write_s;
  logic                   pop_s;
  logic                   issue_s;
  logic [1:0]             stage_count_s;
  logic [2:0]             occupancy_s;
  logic [WORD_WIDTH-1:0]  rdata_s;
  logic                   pop_head_valid_s;
  logic                   pop_skid_valid_s;
  logic [WORD_WIDTH-1:0]  pop_head_s;
  logic [WORD_WIDTH-1:0]  pop_skid_s;
  logic                   head_valid_s;
  logic                   skid_valid_s;
  logic [WORD_WIDTH-1:0]  head_s;
  logic [WORD_WIDTH-1:0]  skid_s;

  function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] ptr);
    if (ptr == ADDR_WIDTH'(VECTOR_LENGTH - 1)) begin
      return {ADDR_WIDTH{1'b0}};
    end else begin
      return ptr + ADDR_WIDTH'(1);
    end
  endfunction

  assign flush_s       = rst_i || clear_i;
  assign in_ready_o    = (ram_count_r < LEVEL_WIDTH'(VECTOR_LENGTH)) && !flush_s;
  assign write_s       = in_valid_i && in_ready_o;
  assign pop_s         = head_valid_r && out_ready_i;
  assign stage_count_s = {1'b0, head_valid_r} + {1'b0, skid_valid_r};
  // Words already committed to the stage after this cycle's pop; never exceeds two.
  assign occupancy_s   = {1'b0, stage_count_s} + {2'b00, pending_r} - {2'b00, pop_s};
  assign issue_s       = (ram_count_r != {LEVEL_WIDTH{1'b0}}) && (occupancy_s < 3'd2) && !flush_s;

  assign pop_head_valid_s = pop_s ? skid_valid_r : head_valid_r;
  assign pop_head_s       = pop_s ? skid_r       : head_r;
  assign pop_skid_valid_s = pop_s ? 1'b0         : skid_valid_r;
  assign pop_skid_s       = skid_r;

  dpram #(
    .VECTOR_LENGTH (VECTOR_LENGTH),
    .WORD_WIDTH    (WORD_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_ram (
    .rclk_i  (clk_i),
    .rclke_i (1'b1),
    .re_i    (issue_s),
    .raddr_i (rptr_r),
    .rdata_o (rdata_s),
    .wclk_i  (clk_i),
    .wclke_i (1'b1),
    .we_i    (write_s),
    .waddr_i (wptr_r),
    .mask_i  ({WORD_WIDTH{1'b0}}),
    .wdata_i (in_data_i)
  );

  // Landing RAM data fills the first free slot after the pop has shifted the stage.
  always_comb begin
    head_valid_s = pop_head_valid_s;
    head_s       = pop_head_s;
    skid_valid_s = pop_skid_valid_s;
    skid_s       = pop_skid_s;
    if (pending_r && !pop_head_valid_s) begin
      head_valid_s = 1'b1;
      head_s       = rdata_s;
    end else if (pending_r) begin
      skid_valid_s = 1'b1;
      skid_s       = rdata_s;
    end else begin
      skid_s       = pop_skid_s;
    end
  end

  // Pointers, RAM occupancy, in-flight read flag and output stage.
  always_ff @(posedge clk_i) begin
    if (flush_s) begin
      wptr_r       <= {ADDR_WIDTH{1'b0}};
      rptr_r       <= {ADDR_WIDTH{1'b0}};
      ram_count_r  <= {LEVEL_WIDTH{1'b0}};
      pending_r    <= 1'b0;
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      head_r       <= {WORD_WIDTH{1'b0}};
      skid_r       <= {WORD_WIDTH{1'b0}};
    end else begin
      if (write_s) begin
        wptr_r <= ptr_next(wptr_r);
      end
      if (issue_s) begin
        rptr_r <= ptr_next(rptr_r);
      end
      case ({write_s, issue_s})
        2'b10:   ram_count_r <= ram_count_r + LEVEL_WIDTH'(1);
        2'b01:   ram_count_r <= ram_count_r - LEVEL_WIDTH'(1);
        default: ram_count_r <= ram_count_r;
      endcase
      pending_r    <= issue_s;
      head_valid_r <= head_valid_s;
      skid_valid_r <= skid_valid_s;
      head_r       <= head_s;
      skid_r       <= skid_s;
    end
  end

  assign out_valid_o = head_valid_r;
  assign out_data_o  = head_r;
  assign level_o     = ram_count_r + LEVEL_WIDTH'(pending_r) + LEVEL_WIDTH'(stage_count_s);

endmodule

// File: tb/tb_dpram_fifo.sv
// Scoreboard bench: three FIFO instances (depth 4/8-bit, depth 5/16-bit, depth 512/32-bit).
module tb_dpram_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0]  in_data_a, out_data_a;
  logic [2:0]  level_a;

  logic        clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [15:0] in_data_b, out_data_b;
  logic [2:0]  level_b;

  logic        clear_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [31:0] in_data_c, out_data_c;
  logic [9:0]  level_c;

  int n_checks = 0;
  int n_errors = 0;
  int n_pop_a  = 0;
  int n_pop_b  = 0;
  int n_pop_c  = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];

  dpram_fifo #(.VECTOR_LENGTH(4), .WORD_WIDTH(8)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .in_data_i(in_data_a), .in_valid_i(in_valid_a),
    .in_ready_o(in_ready_a), .out_data_o(out_data_a), .out_valid_o(out_valid_a),
    .out_ready_i(out_ready_a), .level_o(level_a));

  dpram_fifo #(.VECTOR_LENGTH(5), .WORD_WIDTH(16)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .in_data_i(in_data_b), .in_valid_i(in_valid_b),
    .in_ready_o(in_ready_b), .out_data_o(out_data_b), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready_b), .level_o(level_b));

  dpram_fifo #(.WORD_WIDTH(32)) u_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_c), .in_data_i(in_data_c), .in_valid_i(in_valid_c),
    .in_ready_o(in_ready_c), .out_data_o(out_data_c), .out_valid_o(out_valid_c),
    .out_ready_i(out_ready_c), .level_o(level_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard for instance A: push accepted writes, compare on every pop.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (rst || clear_a) begin
      q_a.delete();
    end else begin
      if (in_valid_a && in_ready_a) q_a.push_back(32'(in_data_a));
      if (out_valid_a && out_ready_a) begin
        n_pop_a++;
        check_eq("a_pop_avail", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          exp_v = q_a.pop_front();
          check_eq("a_data", 32'(out_data_a), exp_v);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (rst || clear_b) begin
      q_b.delete();
    end else begin
      if (in_valid_b && in_ready_b) q_b.push_back(32'(in_data_b));
      if (out_valid_b && out_ready_b) begin
        n_pop_b++;
        check_eq("b_pop_avail", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          exp_v = q_b.pop_front();
          check_eq("b_data", 32'(out_data_b), exp_v);
        end
      end
    end
  end

  // Scoreboard for instance C.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (rst || clear_c) begin
      q_c.delete();
    end else begin
      if (in_valid_c && in_ready_c) q_c.push_back(in_data_c);
      if (out_valid_c && out_ready_c) begin
        n_pop_c++;
        check_eq("c_pop_avail", 32'(q_c.size() != 0), 32'd1);
        if (q_c.size() != 0) begin
          exp_v = q_c.pop_front();
          check_eq("c_data", out_data_c, exp_v);
        end
      end
    end
  end

  initial begin
    logic acc;
    int   idx;
    rst = 1'b1;
    clear_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = 8'h00;
    clear_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = 16'h0000;
    clear_c = 1'b0; in_valid_c = 1'b0; out_ready_c = 1'b0; in_data_c = 32'h0;
    ticks(3);
    check_eq("rst_valid", 32'(out_valid_a), 32'd0);
    check_eq("rst_level", 32'(level_a), 32'd0);
    check_eq("rst_data", 32'(out_data_a), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready_a), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rel_in_ready", 32'(in_ready_a), 32'd1);

    // Latency and order
    out_ready_a = 1'b1;
    in_valid_a = 1'b1; in_data_a = 8'h11; tick();
    in_data_a = 8'h22; tick();
    check_eq("lat_early", 32'(out_valid_a), 32'd0);
    in_data_a = 8'h33; tick();
    in_valid_a = 1'b0;
    check_eq("lat_valid", 32'(out_valid_a), 32'd1);
    check_eq("lat_d0", 32'(out_data_a), 32'h11);
    tick();
    check_eq("lat_d1", 32'(out_data_a), 32'h22);
    tick();
    check_eq("lat_d2", 32'(out_data_a), 32'h33);
    tick();
    check_eq("lat_empty", 32'(out_valid_a), 32'd0);
    check_eq("lat_level", 32'(level_a), 32'd0);

    // Fill: 7 offered, 6 accepted
    out_ready_a = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      in_valid_a = 1'b1; in_data_a = 8'(i); tick();
    end
    in_valid_a = 1'b0;
    ticks(2);
    check_eq("fill_in_ready", 32'(in_ready_a), 32'd0);
    check_eq("fill_level", 32'(level_a), 32'd6);
    check_eq("fill_head", 32'(out_data_a), 32'd1);
    ticks(3);
    check_eq("fill_hold", 32'(out_data_a), 32'd1);
    out_ready_a = 1'b1;
    ticks(10);
    check_eq("fill_drained", 32'(level_a), 32'd0);
    check_eq("fill_pops", 32'(n_pop_a), 32'd9);

    // Simultaneous write and pop at level 3
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a = 1'b1; in_data_a = 8'(8'h40 + i); tick();
    end
    in_valid_a = 1'b0;
    tick();
    check_eq("sim_prime", 32'(level_a), 32'd3);
    for (int i = 0; i < 50; i++) begin
      in_valid_a = 1'b1; out_ready_a = 1'b1; in_data_a = 8'(8'h50 + i);
      tick();
      check_eq("sim_level", 32'(level_a), 32'd3);
    end
    in_valid_a = 1'b0;
    ticks(8);
    check_eq("sim_drained", 32'(level_a), 32'd0);
    check_eq("sim_pops", 32'(n_pop_a), 32'd62);

    // Clear with a read in flight; the write during clear is dropped
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a = 1'b1; in_data_a = 8'(8'h61 + i); tick();
    end
    check_eq("clr_pending", 32'(u_a.pending_r), 32'd1);
    in_data_a = 8'h55; clear_a = 1'b1;
    tick();
    clear_a = 1'b0; in_valid_a = 1'b0;
    check_eq("clr_valid", 32'(out_valid_a), 32'd0);
    check_eq("clr_level", 32'(level_a), 32'd0);
    out_ready_a = 1'b1; in_valid_a = 1'b1; in_data_a = 8'hAA;
    tick();
    in_valid_a = 1'b0;
    check_eq("clr_wait1", 32'(out_valid_a), 32'd0);
    tick();
    check_eq("clr_wait2", 32'(out_valid_a), 32'd0);
    tick();
    check_eq("clr_valid_aa", 32'(out_valid_a), 32'd1);
    check_eq("clr_data_aa", 32'(out_data_a), 32'hAA);
    tick();
    check_eq("clr_only", 32'(out_valid_a), 32'd0);
    check_eq("clr_pops", 32'(n_pop_a), 32'd63);

    // Non-power-of-2 depth with random valid/ready
    idx = 0;
    for (int cyc = 0; cyc < 400 && n_pop_b < 20; cyc++) begin
      in_valid_b  = (idx < 20) && ($urandom_range(0, 3) != 0);
      in_data_b   = 16'(idx);
      out_ready_b = ($urandom_range(0, 2) != 0);
      acc = in_valid_b && in_ready_b;
      tick();
      if (acc) idx++;
    end
    in_valid_b = 1'b0;
    check_eq("wrap_pops", 32'(n_pop_b), 32'd20);
    check_eq("wrap_wptr", 32'(u_b.wptr_r), 32'd0);
    check_eq("wrap_rptr", 32'(u_b.rptr_r), 32'd0);
    check_eq("wrap_level", 32'(level_b), 32'd0);

    // 16-bit values
    out_ready_b = 1'b1;
    in_valid_b = 1'b1; in_data_b = 16'hBEEF; tick();
    in_data_b = 16'h1234; tick();
    in_valid_b = 1'b0;
    ticks(5);
    check_eq("w16_pops", 32'(n_pop_b), 32'd22);

    // 32-bit value on the default-depth instance
    out_ready_c = 1'b1;
    in_valid_c = 1'b1; in_data_c = 32'hDEADBEEF; tick();
    in_valid_c = 1'b0;
    tick();
    check_eq("w32_early", 32'(out_valid_c), 32'd0);
    tick();
    check_eq("w32_valid", 32'(out_valid_c), 32'd1);
    check_eq("w32_data", out_data_c, 32'hDEADBEEF);
    tick();
    check_eq("w32_level", 32'(level_c), 32'd0);
    check_eq("w32_pops", 32'(n_pop_c), 32'd1);

    check_eq("a_sb_empty", 32'(q_a.size()), 32'd0);
    check_eq("b_sb_empty", 32'(q_b.size()), 32'd0);
    check_eq("c_sb_empty", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
